// File: rtl/mem_req_arbiter.sv
// Two-requester round-robin arbiter in front of one memory request port.
// Requester 0 is the CPU cache and requester 1 is the DMA/accelerator.
// Each transaction goes IDLE -> BUSY -> RELEASE, so cs_o is low for at
// least one cycle between back-to-back transactions.
// Optional feature: define ARB_TIMEOUT_EN to enable a watchdog. It ends a
// stuck BUSY after TIMEOUT_CYCLES with zero data and an err_o pulse.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH_CACHE
`define DATA_WIDTH_CACHE 32
`endif

module mem_req_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [`ADDR_WIDTH-1:0]       r0_addr_i,
   input  logic [`DATA_WIDTH_CACHE-1:0] r0_wdata_i,
   input  logic                         r0_we_i,
   input  logic                         r0_cs_i,
   output logic [`DATA_WIDTH_CACHE-1:0] r0_rdata_o,
   output logic                         r0_rvalid_o,
   output logic                         r0_gnt_o,
   input  logic [`ADDR_WIDTH-1:0]       r1_addr_i,
   input  logic [`DATA_WIDTH_CACHE-1:0] r1_wdata_i,
   input  logic                         r1_we_i,
   input  logic                         r1_cs_i,
   output logic [`DATA_WIDTH_CACHE-1:0] r1_rdata_o,
   output logic                         r1_rvalid_o,
   output logic                         r1_gnt_o,
   output logic [`ADDR_WIDTH-1:0]       addr_o,
   output logic [`DATA_WIDTH_CACHE-1:0] wdata_o,
   output logic                         we_o,
   output logic                         cs_o,
   input  logic [`DATA_WIDTH_CACHE-1:0] rdata_i,
   input  logic                         rvalid_i,
   output logic                         err_o
);

   typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

   state_e                       r_state;
   logic                         r_owner;
   logic                         r_last;
   logic                         r_gnt0;
   logic                         r_gnt1;
   logic                         r_we;
   logic [`ADDR_WIDTH-1:0]       r_addr;
   logic [`DATA_WIDTH_CACHE-1:0] r_wdata;

   logic                         w_busy;
   logic                         w_any_req;
   logic                         w_sel;
   logic                         w_timeout;
   logic                         w_done;
   logic [`DATA_WIDTH_CACHE-1:0] w_rdata;

   assign w_busy    = (r_state == StBusy);
   assign w_any_req = r0_cs_i | r1_cs_i;
   // On a tie the requester that was not the last owner wins.
   assign w_sel     = (r0_cs_i & r1_cs_i) ? ~r_last : r1_cs_i;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] r_cnt;

   // r_cnt holds the number of BUSY cycles already elapsed, so the limit hits on the last one.
   assign w_timeout = w_busy & ~rvalid_i & (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

   // Watchdog counter: cleared while idle (i.e. on entry to BUSY), counts BUSY cycles.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (r_state == StIdle) begin
         r_cnt <= '0;
      end else if (w_busy) begin
         r_cnt <= r_cnt + CntW'(1);
      end
   end
`else
   logic w_unused_timeout;

   assign w_unused_timeout = ^TIMEOUT_CYCLES;
   assign w_timeout        = 1'b0;
`endif

   assign w_done = w_busy & (rvalid_i | w_timeout);

   // A real response takes precedence over a timeout; a timeout returns zero data.
   assign w_rdata = (w_busy & rvalid_i) ? rdata_i : '0;

   assign r0_rdata_o  = r_owner ? '0 : w_rdata;
   assign r1_rdata_o  = r_owner ? w_rdata : '0;
   assign r0_rvalid_o = w_done & ~r_owner;
   assign r1_rvalid_o = w_done & r_owner;
   assign r0_gnt_o    = r_gnt0;
   assign r1_gnt_o    = r_gnt1;
   assign err_o       = w_timeout;
   assign cs_o        = w_busy;
   assign addr_o      = r_addr;
   assign wdata_o     = r_wdata;
   assign we_o        = r_we;

   // Arbitration FSM: latch the winner's request, hold it through BUSY, then one RELEASE cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= StIdle;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_any_req) begin
                  r_state <= StBusy;
                  r_owner <= w_sel;
                  r_addr  <= w_sel ? r1_addr_i : r0_addr_i;
                  r_wdata <= w_sel ? r1_wdata_i : r0_wdata_i;
                  r_we    <= w_sel ? r1_we_i : r0_we_i;
                  r_gnt0  <= ~w_sel;
                  r_gnt1  <= w_sel;
               end
            end
            StBusy: begin
               // The owner's cs is ignored here so a dropped request still completes.
               if (w_done) begin
                  r_state <= StRelease;
                  r_last  <= r_owner;
                  r_gnt0  <= 1'b0;
                  r_gnt1  <= 1'b0;
               end
            end
            StRelease: r_state <= StIdle;
            default:   r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter. Expected responses are queued when
// the downstream reply is driven and compared when a requester rvalid fires.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH_CACHE
`define DATA_WIDTH_CACHE 32
`endif

module tb_mem_req_arbiter;

   localparam int unsigned AW = `ADDR_WIDTH;
   localparam int unsigned DW = `DATA_WIDTH_CACHE;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic [AW-1:0] r0_addr_i, r1_addr_i, addr_o;
   logic [DW-1:0] r0_wdata_i, r1_wdata_i, wdata_o, rdata_i;
   logic [DW-1:0] r0_rdata_o, r1_rdata_o;
   logic          r0_we_i, r0_cs_i, r1_we_i, r1_cs_i;
   logic          r0_rvalid_o, r0_gnt_o, r1_rvalid_o, r1_gnt_o;
   logic          we_o, cs_o, rvalid_i, err_o;

   typedef struct {
      logic          id;
      logic [DW-1:0] data;
      logic          err;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   mem_req_arbiter #(.TIMEOUT_CYCLES(8)) u_dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .r0_addr_i  (r0_addr_i),
      .r0_wdata_i (r0_wdata_i),
      .r0_we_i    (r0_we_i),
      .r0_cs_i    (r0_cs_i),
      .r0_rdata_o (r0_rdata_o),
      .r0_rvalid_o(r0_rvalid_o),
      .r0_gnt_o   (r0_gnt_o),
      .r1_addr_i  (r1_addr_i),
      .r1_wdata_i (r1_wdata_i),
      .r1_we_i    (r1_we_i),
      .r1_cs_i    (r1_cs_i),
      .r1_rdata_o (r1_rdata_o),
      .r1_rvalid_o(r1_rvalid_o),
      .r1_gnt_o   (r1_gnt_o),
      .addr_o     (addr_o),
      .wdata_o    (wdata_o),
      .we_o       (we_o),
      .cs_o       (cs_o),
      .rdata_i    (rdata_i),
      .rvalid_i   (rvalid_i),
      .err_o      (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_ni     = 1'b0;
      r0_cs_i    = 1'b0;
      r1_cs_i    = 1'b0;
      r0_we_i    = 1'b0;
      r1_we_i    = 1'b0;
      r0_addr_i  = '0;
      r1_addr_i  = '0;
      r0_wdata_i = '0;
      r1_wdata_i = '0;
      rvalid_i   = 1'b0;
      rdata_i    = '0;
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
   endtask

   // Waits, then returns one downstream response and drops the owner's request.
   // Ends in the RELEASE cycle.
   task automatic serve(input logic id, input logic [DW-1:0] d, input int wait_cycles);
      repeat (wait_cycles) tick();
      rvalid_i = 1'b1;
      rdata_i  = d;
      sb_q.push_back('{id: id, data: d, err: 1'b0});
      tick();
      rvalid_i = 1'b0;
      rdata_i  = '0;
      if (id) r1_cs_i = 1'b0;
      else    r0_cs_i = 1'b0;
   endtask

   // Response monitor / scoreboard consumer.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         check_eq("gnt_onehot", {63'b0, r0_gnt_o & r1_gnt_o}, 64'd0);
         check_eq("err_without_rvalid", {63'b0, err_o & ~(r0_rvalid_o | r1_rvalid_o)}, 64'd0);
         if (r0_rvalid_o || r1_rvalid_o) begin
            if (sb_q.size() == 0) begin
               check_eq("spurious_rvalid", {62'b0, r1_rvalid_o, r0_rvalid_o}, 64'd0);
            end else begin
               mon_e = sb_q.pop_front();
               check_eq("rvalid_owner", {62'b0, r1_rvalid_o, r0_rvalid_o},
                        mon_e.id ? 64'd2 : 64'd1);
               check_eq("rdata_owner", mon_e.id ? r1_rdata_o : r0_rdata_o, mon_e.data);
               check_eq("rdata_nonowner", mon_e.id ? r0_rdata_o : r1_rdata_o, 64'd0);
               check_eq("err_pulse", {63'b0, err_o}, {63'b0, mon_e.err});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want test end");
      $fatal(1, "bench timeout");
   end

   initial begin
      // Reset values
      do_reset();
      rst_ni = 1'b0;
      #1;
      check_eq("rst_cs", {63'b0, cs_o}, 64'd0);
      check_eq("rst_addr", addr_o, 64'd0);
      check_eq("rst_gnt", {62'b0, r1_gnt_o, r0_gnt_o}, 64'd0);
      check_eq("rst_err", {63'b0, err_o}, 64'd0);
      do_reset();

      // Tie after reset: r0 first, then r1, then a repeat tie goes to r0
      r0_cs_i = 1'b1; r0_addr_i = 'h10;
      r1_cs_i = 1'b1; r1_addr_i = 'h20;
      tick();
      @(negedge clk_i);
      check_eq("tie1_gnt", {62'b0, r1_gnt_o, r0_gnt_o}, 64'd1);
      check_eq("tie1_addr", addr_o, 64'h10);
      serve(1'b0, 'h11, 1);
      @(negedge clk_i);
      check_eq("tie1_release_cs", {63'b0, cs_o}, 64'd0);
      tick();
      tick();
      @(negedge clk_i);
      check_eq("tie1_r1_gnt", {62'b0, r1_gnt_o, r0_gnt_o}, 64'd2);
      check_eq("tie1_r1_addr", addr_o, 64'h20);
      serve(1'b1, 'h22, 0);
      r0_cs_i = 1'b1;
      r1_cs_i = 1'b1;
      tick();
      tick();
      @(negedge clk_i);
      check_eq("tie2_gnt", {62'b0, r1_gnt_o, r0_gnt_o}, 64'd1);
      serve(1'b0, 'h33, 0);
      tick();
      tick();
      @(negedge clk_i);
      check_eq("tie2_r1_gnt", {62'b0, r1_gnt_o, r0_gnt_o}, 64'd2);
      serve(1'b1, 'h44, 0);
      tick();

      // Single r0 read at 0x100, reply in the third BUSY cycle
      r0_cs_i = 1'b1; r0_addr_i = 'h100; r0_we_i = 1'b0;
      @(negedge clk_i);
      check_eq("rd_pre_cs", {63'b0, cs_o}, 64'd0);
      tick();
      @(negedge clk_i);
      check_eq("rd_cs", {63'b0, cs_o}, 64'd1);
      check_eq("rd_addr", addr_o, 64'h100);
      check_eq("rd_we", {63'b0, we_o}, 64'd0);
      serve(1'b0, 'hA5, 2);
      @(negedge clk_i);
      check_eq("rd_release_cs", {63'b0, cs_o}, 64'd0);
      check_eq("rd_release_gnt", {62'b0, r1_gnt_o, r0_gnt_o}, 64'd0);
      tick();

      // r1 write held stable while r0 inputs toggle
      r1_cs_i = 1'b1; r1_addr_i = 'h200; r1_wdata_i = 'h1234; r1_we_i = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         r0_addr_i  = $urandom;
         r0_wdata_i = $urandom;
         @(negedge clk_i);
         check_eq("wr_addr", addr_o, 64'h200);
         check_eq("wr_wdata", wdata_o, 64'h1234);
         check_eq("wr_we", {63'b0, we_o}, 64'd1);
         check_eq("wr_cs", {63'b0, cs_o}, 64'd1);
         tick();
      end
      serve(1'b1, 'h5A, 0);
      r1_we_i = 1'b0;
      tick();

      // rvalid_i while IDLE is ignored
      rvalid_i = 1'b1; rdata_i = 'hFF;
      @(negedge clk_i);
      check_eq("idle_rvalid", {62'b0, r1_rvalid_o, r0_rvalid_o}, 64'd0);
      check_eq("idle_cs", {63'b0, cs_o}, 64'd0);
      tick();
      rvalid_i = 1'b0; rdata_i = '0;
      @(negedge clk_i);
      check_eq("idle_stay_cs", {63'b0, cs_o}, 64'd0);
      tick();

      // Asynchronous reset in the middle of BUSY
      r0_cs_i = 1'b1; r0_addr_i = 'h300; r0_wdata_i = 'h77; r0_we_i = 1'b1;
      tick();
      #2 rst_ni = 1'b0;
      #1;
      check_eq("mid_rst_cs", {63'b0, cs_o}, 64'd0);
      check_eq("mid_rst_addr", addr_o, 64'd0);
      check_eq("mid_rst_wdata", wdata_o, 64'd0);
      check_eq("mid_rst_we", {63'b0, we_o}, 64'd0);
      check_eq("mid_rst_gnt", {62'b0, r1_gnt_o, r0_gnt_o}, 64'd0);
      r0_cs_i = 1'b0; r0_we_i = 1'b0;
      rvalid_i = 1'b1; rdata_i = 'hBB;
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      @(negedge clk_i);
      check_eq("late_rvalid", {62'b0, r1_rvalid_o, r0_rvalid_o}, 64'd0);
      check_eq("late_cs", {63'b0, cs_o}, 64'd0);
      tick();
      rvalid_i = 1'b0; rdata_i = '0;
      tick();

`ifdef ARB_TIMEOUT_EN
      // Timeout on the 8th BUSY cycle
      r0_cs_i = 1'b1;
      tick();
      for (int i = 1; i < 8; i++) begin
         @(negedge clk_i);
         check_eq("to_wait_err", {63'b0, err_o}, 64'd0);
         check_eq("to_wait_cs", {63'b0, cs_o}, 64'd1);
         tick();
      end
      sb_q.push_back('{id: 1'b0, data: '0, err: 1'b1});
      tick();
      r0_cs_i = 1'b0;
      @(negedge clk_i);
      check_eq("to_release_cs", {63'b0, cs_o}, 64'd0);
      tick();
      // Response in the timeout cycle wins over the watchdog
      r1_cs_i = 1'b1;
      tick();
      repeat (7) tick();
      serve(1'b1, 'h77, 0);
      tick();
`else
      // Without the watchdog, BUSY waits indefinitely
      r0_cs_i = 1'b1;
      tick();
      repeat (99) tick();
      @(negedge clk_i);
      check_eq("nto_cs", {63'b0, cs_o}, 64'd1);
      check_eq("nto_err", {63'b0, err_o}, 64'd0);
      check_eq("nto_gnt", {62'b0, r1_gnt_o, r0_gnt_o}, 64'd1);
      serve(1'b0, 'h99, 0);
      tick();
`endif

      tick();
      check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
